// File: rtl/if_stage_if.sv
// Fetch-stage bus between the PC stage (master) and if_stage (slave):
// the request/control inputs and the instruction handed to decode.
interface if_stage_if;
  logic        cpu_stat_if;
  logic [31:2] pc;
  logic        stall;
  logic        flush;
  logic [31:0] inst_id;
  logic [31:2] pc_id;
  logic        if_done;
  logic        inst_fault;
  logic        if_busy;

  modport master (
    output cpu_stat_if, pc, stall, flush,
    input  inst_id, pc_id, if_done, inst_fault, if_busy
  );

  modport slave (
    input  cpu_stat_if, pc, stall, flush,
    output inst_id, pc_id, if_done, inst_fault, if_busy
  );
endinterface

// File: rtl/if_stage.sv
// if_stage: RV32I instruction fetch with a private single-port instruction RAM.
// Defining IMEM_DBG_PORT_EN adds a debug read/write port sharing that RAM port.
module if_stage #(
  parameter int          IWIDTH   = 11,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              rst,
`ifdef IMEM_DBG_PORT_EN
  input  logic              dbg_we,
  input  logic              dbg_re,
  input  logic [IWIDTH-1:0] dbg_adr,
  input  logic [31:0]       dbg_wdata,
  output logic [31:0]       dbg_rdata,
`endif
  if_stage_if.slave         bus
);

  typedef enum logic [1:0] {IDLE, RD, CAP} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [31:0]       mem [0:(1<<IWIDTH)-1];
  logic [31:2]       pc_lat;
  logic              fault_lat;
  logic [31:0]       ram_q;
  logic [31:0]       inst_q;
  logic [31:2]       pc_q;
  logic [IWIDTH-1:0] ram_adr;
  logic              ram_we;
  logic [31:0]       ram_wdata;
  logic              dbg_hit;
  logic              accept;
  logic              load;
  logic              fetch_rd;
  logic [31:0]       fetch_word;

`ifdef IMEM_DBG_PORT_EN
  // A debug access owns the single RAM port for the cycle and makes RD repeat.
  assign dbg_hit   = dbg_we | dbg_re;
  assign ram_we    = dbg_we & ~rst;
  assign ram_wdata = dbg_wdata;
  assign ram_adr   = dbg_hit ? dbg_adr : pc_lat[IWIDTH+1:2];
`else
  assign dbg_hit   = 1'b0;
  assign ram_we    = 1'b0;
  assign ram_wdata = '0;
  assign ram_adr   = pc_lat[IWIDTH+1:2];
`endif

  assign accept     = (state == IDLE) && bus.cpu_stat_if && !bus.flush;
  assign load       = (state == CAP) && !bus.flush && !rst;
  assign fetch_rd   = (state == RD) && !dbg_hit && !fault_lat;
  assign fetch_word = fault_lat ? 32'h0000_0000 : ram_q;

  always @(posedge clk) begin
    if (ram_we)
      mem[ram_adr] <= ram_wdata;
  end

  // Out-of-range fetches never touch the RAM; their result is forced to zero.
  always_ff @(posedge clk) begin
    if (fetch_rd)
      ram_q <= mem[ram_adr];
  end

`ifdef IMEM_DBG_PORT_EN
  always_ff @(posedge clk) begin
    if (rst)
      dbg_rdata <= '0;
    else if (dbg_re && !dbg_we)
      dbg_rdata <= mem[ram_adr];
  end
`endif

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.cpu_stat_if) state_nxt = RD;
      RD:      if (!dbg_hit && !bus.stall) state_nxt = CAP;
      CAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (bus.flush)
      state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_lat    <= '0;
      fault_lat <= 1'b0;
      inst_q    <= NOP_INST;
      pc_q      <= '0;
    end else begin
      if (accept) begin
        pc_lat    <= bus.pc;
        fault_lat <= |bus.pc[31:IWIDTH+2];
      end
      if (bus.flush) begin
        inst_q <= NOP_INST;
      end else if (load) begin
        inst_q <= fetch_word;
        pc_q   <= pc_lat;
      end
    end
  end

  // CAP forwards the fresh word straight to decode so it is usable in the if_done cycle.
  assign bus.inst_id    = load ? fetch_word : inst_q;
  assign bus.pc_id      = load ? pc_lat : pc_q;
  assign bus.if_done    = load;
  assign bus.inst_fault = load && fault_lat;
  assign bus.if_busy    = (state != IDLE);

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios plus randomized fetches
// compared against a word-array model of the instruction RAM.
module tb_if_stage;
  localparam int          IWIDTH = 11;
  localparam int          DEPTH  = 1 << IWIDTH;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  logic [31:0] model_mem [0:DEPTH-1];
  logic [31:0] exp_inst;
  logic [31:2] exp_pc;

  if_stage_if bus();

`ifdef IMEM_DBG_PORT_EN
  logic              dbg_we;
  logic              dbg_re;
  logic [IWIDTH-1:0] dbg_adr;
  logic [31:0]       dbg_wdata;
  logic [31:0]       dbg_rdata;
`endif

  if_stage #(.IWIDTH(IWIDTH), .NOP_INST(NOP)) dut (
    .clk       (clk),
    .rst       (rst),
`ifdef IMEM_DBG_PORT_EN
    .dbg_we    (dbg_we),
    .dbg_re    (dbg_re),
    .dbg_adr   (dbg_adr),
    .dbg_wdata (dbg_wdata),
    .dbg_rdata (dbg_rdata),
`endif
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired before summary");
    $fatal(1, "[TB] watchdog");
  end

  // Inputs change on the falling edge; outputs are sampled 2 ns later.
  task automatic applyStimulus(input logic cs, input logic [31:2] p, input logic st,
                               input logic fl, input logic rs);
    @(negedge clk);
    bus.cpu_stat_if = cs;
    bus.pc          = p;
    bus.stall       = st;
    bus.flush       = fl;
    rst             = rs;
    #2;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkHeld(input string tag);
    checkOutput({tag, "_inst"}, bus.inst_id, exp_inst);
    checkOutput({tag, "_pc"}, 32'(bus.pc_id), 32'(exp_pc));
  endtask

  // One complete fetch: request, nstall stall cycles in RD, capture, one idle cycle.
  task automatic runFetch(input logic [31:2] p, input int nstall, input logic extraReq);
    logic [31:0] wa;
    logic        expf;
    logic [31:0] expw;
    wa   = {2'b00, p};
    expf = (wa >= 32'(DEPTH));
    expw = expf ? 32'h0 : model_mem[wa[IWIDTH-1:0]];
    applyStimulus(1'b1, p, 1'b0, 1'b0, 1'b0);
    checkOutput("req_done", 32'(bus.if_done), 32'd0);
    checkOutput("req_busy", 32'(bus.if_busy), 32'd0);
    for (int k = 1; k <= nstall + 2; k++) begin
      applyStimulus(extraReq && (k == 1), ~p, (k <= nstall), 1'b0, 1'b0);
      checkOutput("busy", 32'(bus.if_busy), 32'd1);
      if (k == nstall + 2) begin
        checkOutput("done", 32'(bus.if_done), 32'd1);
        checkOutput("inst", bus.inst_id, expw);
        checkOutput("pc_id", 32'(bus.pc_id), 32'(p));
        checkOutput("fault", 32'(bus.inst_fault), 32'(expf));
        exp_inst = expw;
        exp_pc   = p;
      end else begin
        checkOutput("early_done", 32'(bus.if_done), 32'd0);
      end
    end
    applyStimulus(1'b0, p, 1'b0, 1'b0, 1'b0);
    checkOutput("after_busy", 32'(bus.if_busy), 32'd0);
    checkOutput("after_done", 32'(bus.if_done), 32'd0);
    checkHeld("hold");
  endtask

  initial begin
    logic [31:2] rp;
    errors          = 0;
    checks          = 0;
    rst             = 1'b1;
    bus.cpu_stat_if = 1'b0;
    bus.pc          = '0;
    bus.stall       = 1'b0;
    bus.flush       = 1'b0;
`ifdef IMEM_DBG_PORT_EN
    dbg_we    = 1'b0;
    dbg_re    = 1'b0;
    dbg_adr   = '0;
    dbg_wdata = '0;
`endif
    for (int i = 0; i < DEPTH; i++) begin
      model_mem[i] = $urandom;
      dut.mem[i]   = model_mem[i];
    end
    model_mem[4] = 32'h0050_0093;
    dut.mem[4]   = 32'h0050_0093;
    exp_inst = NOP;
    exp_pc   = '0;

    $display("[TB] reset");
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
    checkHeld("rst");
    checkOutput("rst_done", 32'(bus.if_done), 32'd0);
    checkOutput("rst_fault", 32'(bus.inst_fault), 32'd0);
    checkOutput("rst_busy", 32'(bus.if_busy), 32'd0);
`ifdef IMEM_DBG_PORT_EN
    checkOutput("rst_dbg_rdata", dbg_rdata, 32'd0);
`endif

    $display("[TB] basic fetch and stalled fetch");
    runFetch(30'd4, 0, 1'b0);
    runFetch(30'd9, 3, 1'b1);

    $display("[TB] flush in RD");
    applyStimulus(1'b1, 30'd4, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 30'd4, 1'b0, 1'b1, 1'b0);
    checkOutput("flrd_done", 32'(bus.if_done), 32'd0);
    checkOutput("flrd_busy", 32'(bus.if_busy), 32'd1);
    exp_inst = NOP;
    applyStimulus(1'b0, 30'd4, 1'b0, 1'b0, 1'b0);
    checkOutput("flrd_busy_after", 32'(bus.if_busy), 32'd0);
    checkOutput("flrd_done_after", 32'(bus.if_done), 32'd0);
    checkHeld("flrd");

    $display("[TB] flush in CAP and flush with request");
    runFetch(30'd4, 0, 1'b0);
    applyStimulus(1'b1, 30'd7, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 30'd7, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 30'd7, 1'b0, 1'b1, 1'b0);
    checkOutput("flcap_done", 32'(bus.if_done), 32'd0);
    exp_inst = NOP;
    applyStimulus(1'b1, 30'd8, 1'b0, 1'b1, 1'b0);
    checkHeld("flcap");
    applyStimulus(1'b0, 30'd8, 1'b0, 1'b0, 1'b0);
    checkOutput("flreq_busy", 32'(bus.if_busy), 32'd0);

    $display("[TB] out-of-range fetch");
    runFetch(30'h0000_1000, 0, 1'b0);

    $display("[TB] reset in RD");
    runFetch(30'd5, 0, 1'b0);
    applyStimulus(1'b1, 30'd4, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 30'd4, 1'b0, 1'b0, 1'b1);
    checkOutput("rstrd_done", 32'(bus.if_done), 32'd0);
    exp_inst = NOP;
    exp_pc   = '0;
    applyStimulus(1'b0, 30'd4, 1'b0, 1'b0, 1'b0);
    checkOutput("rstrd_done_after", 32'(bus.if_done), 32'd0);
    checkOutput("rstrd_busy", 32'(bus.if_busy), 32'd0);
    checkOutput("rstrd_fault", 32'(bus.inst_fault), 32'd0);
    checkHeld("rstrd");
    runFetch(30'd4, 0, 1'b0);

`ifdef IMEM_DBG_PORT_EN
    $display("[TB] debug write collides with fetch");
    applyStimulus(1'b1, 30'd4, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 30'd4, 1'b0, 1'b0, 1'b0);
    dbg_we = 1'b1; dbg_adr = 11'd4; dbg_wdata = 32'hDEAD_BEEF;
    model_mem[4] = 32'hDEAD_BEEF;
    checkOutput("dbg_n1_done", 32'(bus.if_done), 32'd0);
    applyStimulus(1'b0, 30'd4, 1'b0, 1'b0, 1'b0);
    dbg_we = 1'b0;
    checkOutput("dbg_n2_done", 32'(bus.if_done), 32'd0);
    applyStimulus(1'b0, 30'd4, 1'b0, 1'b0, 1'b0);
    checkOutput("dbg_n3_done", 32'(bus.if_done), 32'd1);
    checkOutput("dbg_n3_inst", bus.inst_id, 32'hDEAD_BEEF);
    exp_inst = 32'hDEAD_BEEF;
    exp_pc   = 30'd4;
    applyStimulus(1'b0, 30'd4, 1'b0, 1'b0, 1'b0);
    dbg_re = 1'b1; dbg_adr = 11'd4;
    applyStimulus(1'b0, 30'd4, 1'b0, 1'b0, 1'b0);
    dbg_we = 1'b1; dbg_adr = 11'd5; dbg_wdata = 32'h1234_5678;
    model_mem[5] = 32'h1234_5678;
    checkOutput("dbg_rdata", dbg_rdata, 32'hDEAD_BEEF);
    applyStimulus(1'b0, 30'd4, 1'b0, 1'b0, 1'b0);
    dbg_we = 1'b0;
    checkOutput("dbg_we_re_hold", dbg_rdata, 32'hDEAD_BEEF);
    applyStimulus(1'b0, 30'd4, 1'b0, 1'b0, 1'b0);
    dbg_re = 1'b0;
    checkOutput("dbg_rdata5", dbg_rdata, 32'h1234_5678);
    runFetch(30'd5, 1, 1'b0);
`endif

    $display("[TB] randomized fetches");
    for (int it = 0; it < 24; it++) begin
      rp = 30'($urandom_range(0, DEPTH - 1));
      if ($urandom_range(0, 5) == 0)
        rp = 30'($urandom) | 30'(DEPTH);
      runFetch(rp, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the tiny RV32I core. It sits directly downstream of the PC stage and owns the instruction RAM. On a fetch request it reads the word addressed by `pc`, then hands the instruction and its address to the decode stage. It handles stall, flush (jump, interrupt or exception abort), out-of-range fetch faults and, optionally, a debug RAM access port.

## Interface
Parameters:
- `IWIDTH`, default 11: instruction RAM word-address width (2^IWIDTH x 32-bit words; 8 KB at default).
- `NOP_INST`, default 32'h0000_0013: word driven on `inst_id` after reset and after a flush (`addi x0,x0,0`).

Ports:
- `clk`  in  1  single clock; all logic on its rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `cpu_stat_if`  in  1  one-cycle fetch request pulse; `pc` is valid in the same cycle.
- `pc`  in  [31:2]  word address of the instruction to fetch.
- `stall`  in  1  freezes fetch progress.
- `flush`  in  1  aborts an in-flight fetch.
- `inst_id`  out  [31:0]  fetched instruction for decode.
- `pc_id`  out  [31:2]  address of `inst_id`.
- `if_done`  out  1  one-cycle pulse: `inst_id`/`pc_id` updated this cycle.
- `inst_fault`  out  1  pulses with `if_done` when the fetch was out of range.
- `if_busy`  out  1  high while the FSM is not IDLE.
- Present only with `IMEM_DBG_PORT_EN`:
  - `dbg_we`  in  1  debug write strobe.
  - `dbg_re`  in  1  debug read strobe.
  - `dbg_adr`  in  [IWIDTH-1:0]  debug word address.
  - `dbg_wdata`  in  [31:0]  debug write data.
  - `dbg_rdata`  out  [31:0]  debug read data.

## Operation
- Instruction RAM: 2^IWIDTH x 32, one port, synchronous read with 1-cycle latency. The RAM address is `pc_lat[IWIDTH+1:2]`.
- On `cpu_stat_if`, `pc` is captured into `pc_lat`.
- In range: `pc[31:IWIDTH+2] == 0`. Otherwise the fetch is out of range, the RAM is not read, and the result is 32'h0000_0000 with `inst_fault` asserted.
- FSM states and transitions:
  - IDLE: on `cpu_stat_if`, capture `pc`, go to RD.
  - RD: RAM address presented. Next state is CAP unless `flush` (go to IDLE), `stall`, or a debug access is active this cycle (stay in RD and re-read).
  - CAP: load RAM data (or 0 on fault) into `inst_id`, load `pc_lat` into `pc_id`, pulse `if_done`. Next state is IDLE. `flush` in CAP suppresses the load and `if_done`, and loads `NOP_INST` instead.
- `flush` in any state: FSM goes to IDLE and `inst_id` is set to `NOP_INST`. `pc_id` is unchanged.
- `cpu_stat_if` while not IDLE: ignored, no state change.
- Priority: `rst` > `flush` > debug access > `stall` > normal progress.
- Outputs `inst_id` and `pc_id` hold their values between fetches.

## Timing
- Reset values: `inst_id` = `NOP_INST`, `pc_id` = 0, `if_done` = 0, `inst_fault` = 0, `if_busy` = 0, `dbg_rdata` = 0. FSM in IDLE.
- Latency: `cpu_stat_if` in cycle N gives `if_done` in cycle N+2, with `inst_id` valid from N+2 and held afterwards.
- Each stall cycle or debug-collision cycle spent in RD adds exactly one cycle of latency.
- `if_busy` is high in cycles N+1 and N+2.
- Minimum request spacing is 3 cycles.
- A reset asserted mid-fetch aborts the fetch with no `if_done`. Outputs take their reset values on the next edge.
- `flush` coincident with `cpu_stat_if` in IDLE: the request is dropped.

## Configuration
- `IMEM_DBG_PORT_EN` defined:
  - Debug ports exist and share the RAM port with fetch.
  - `dbg_we` writes `dbg_wdata` at `dbg_adr` on that edge.
  - `dbg_re` returns the word on `dbg_rdata` one cycle later.
  - A debug access takes priority over fetch and forces RD to repeat.
  - `dbg_we` and `dbg_re` together: write wins, `dbg_rdata` unchanged.
- `IMEM_DBG_PORT_EN` undefined: debug ports are absent. The RAM is written only by initialisation, and fetch never repeats for collisions.

## Test plan
- Reset, then RAM[4] = 32'h0050_0093; `cpu_stat_if` with `pc`=4 -> `if_done` 2 cycles later, `inst_id`=32'h0050_0093, `pc_id`=4, `inst_fault`=0.
- `stall` held 3 cycles starting the cycle after `cpu_stat_if` -> `if_done` at N+5, correct data. A second `cpu_stat_if` during busy is ignored.
- `flush` in the cycle after `cpu_stat_if` -> no `if_done`, `inst_id`=32'h0000_0013, `if_busy` low next cycle.
- `pc`=30'h0000_1000 with `IWIDTH`=11 -> `if_done` at N+2, `inst_fault`=1, `inst_id`=0.
- With `IMEM_DBG_PORT_EN`: `dbg_we` to address 4 with 32'hDEAD_BEEF in the RD cycle of a fetch of `pc`=4 -> fetch repeats, `if_done` at N+3 with `inst_id`=32'hDEAD_BEEF. A `dbg_re` of address 4 returns 32'hDEAD_BEEF one cycle later.
- Assert `rst` in the RD cycle -> no `if_done`, all outputs at reset values, a fresh fetch completes normally afterwards.
